// File: rtl/apb4_ram_slave.sv
// APB4 slave that wraps a word-organised RAM with byte strobes and wait states.
// Ports: PCLK/PRESETn, APB4 requester inputs, registered PRDATA/PREADY/PSLVERR.
module apb4_ram_slave #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DEPTH       = 768,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned LSB = $clog2(NB);
  localparam int unsigned IW  = ADDR_WIDTH - LSB;
  localparam int unsigned MW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]            cnt_q;
  logic [IW-1:0]         idx_q;
  logic                  wr_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [NB-1:0]         strb_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          setup;
  logic [IW-1:0] pidx;
  logic          perr;
  logic [IW-1:0] rd_idx;
  logic          rd_wr;
  logic          rd_err;
  logic          unused_addr;

  assign setup       = PSEL & ~PENABLE;
  assign pidx        = PADDR[ADDR_WIDTH-1:LSB];
  assign perr        = 32'(pidx) >= DEPTH;
  assign unused_addr = ^PADDR;

  // With zero wait states DONE is entered straight from the setup
  // cycle, before the request is latched, so use the live bus there.
  always_comb begin
    rd_idx = idx_q;
    rd_wr  = wr_q;
    rd_err = err_q;
    if (state_q == S_IDLE) begin
      rd_idx = pidx;
      rd_wr  = PWRITE;
      rd_err = perr;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (setup) begin
          state_d = (WAIT_STATES == 0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!PSEL) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == S_IDLE && setup) begin
        idx_q   <= pidx;
        wr_q    <= PWRITE;
        err_q   <= perr;
        wdata_q <= PWDATA;
        strb_q  <= PSTRB;
        cnt_q   <= (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
      end else if (state_q == S_WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      // Read data lives only for the DONE cycle.
      rdata_q <= '0;
      if (state_d == S_DONE && !rd_wr && !rd_err) begin
        rdata_q <= mem[MW'(rd_idx)];
      end
    end
  end

  // Contents are intentionally not reset.
  always_ff @(posedge PCLK) begin
    if (state_q == S_DONE && wr_q && !err_q) begin
      for (int i = 0; i < NB; i++) begin
        if (strb_q[i]) begin
          mem[MW'(idx_q)][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    PREADY  = (state_q == S_DONE);
    PSLVERR = (state_q == S_DONE) & err_q;
    PRDATA  = rdata_q;
  end

endmodule

// File: doc/apb4_ram_slave.md
# apb4_ram_slave

APB4 slave that wraps an internal word-organised RAM and generalises the first-generation APB RAM interface. It adds byte-lane write strobes, programmable wait states, an address range check with PSLVERR, and a proper setup/access state machine with asynchronous reset. It sits on the peripheral bus behind the APB bridge as general-purpose scratch or buffer memory.

## Interface
- DATA_WIDTH, 32: bus and word width in bits; must be 8, 16, 32 or 64.
- ADDR_WIDTH, 12: width of PADDR in bits; PADDR is a byte address.
- DEPTH, 768: number of implemented words; must not exceed 2^(ADDR_WIDTH - log2(DATA_WIDTH/8)).
- WAIT_STATES, 1: number of access-phase cycles with PREADY low before completion; valid range 0–15.

Ports:
- PCLK, input, 1: clock; all logic is rising-edge.
- PRESETn, input, 1: asynchronous, active-low reset.
- PSEL, input, 1: slave select.
- PENABLE, input, 1: access phase.
- PWRITE, input, 1: 1 = write, 0 = read.
- PADDR, input, ADDR_WIDTH: byte address.
- PWDATA, input, DATA_WIDTH: write data.
- PSTRB, input, DATA_WIDTH/8: write byte enables; ignored on reads.
- PRDATA, output, DATA_WIDTH: read data.
- PREADY, output, 1: transfer completes in this cycle.
- PSLVERR, output, 1: error response; valid only while PREADY = 1.

## Operation
- Word index is PADDR[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]. The low byte-offset bits are ignored, so misaligned addresses are not an error.
- Address error: the word index is ≥ DEPTH.
- FSM states: IDLE, WAIT, DONE.
- IDLE: on PSEL=1 and PENABLE=0 (setup cycle), latch PADDR, PWRITE, PWDATA, PSTRB and the error flag.
  - If WAIT_STATES=0, go to DONE.
  - Otherwise load the wait counter with WAIT_STATES-1 and go to WAIT.
- WAIT: PREADY=0.
  - If PSEL=0, abort and go to IDLE; no write, no response.
  - If counter = 0, go to DONE; otherwise decrement.
- DONE: PREADY=1, always for exactly one cycle, then go to IDLE. The next cycle may be the setup cycle of a back-to-back transfer and must be accepted.
- Write commit: at the rising edge that ends DONE, for each byte lane i with PSTRB[i]=1, mem[index] byte i ← PWDATA byte i.
  - No commit if the address is in error.
  - PSTRB = 0 is a legal no-op with PSLVERR=0.
- Read: PRDATA is registered with mem[index] on the edge entering DONE, and is 0 in every other cycle. On an address error, PRDATA=0.
- PSLVERR = error flag during DONE, 0 otherwise.
- Memory contents are not reset and are undefined until written.
- Read-after-write to the same address in the next transfer returns the new data.

## Timing
- Reset (PRESETn=0, asynchronous): state IDLE, PREADY=0, PSLVERR=0, PRDATA=0, wait counter 0.
- Reset asserted mid-transfer: the transfer is abandoned with no memory write. Outputs go to reset values immediately, not at the next edge.
- Setup cycle is T0; first access cycle is T1.
  - PREADY is high in cycle T1+WAIT_STATES.
  - Total transfer length is WAIT_STATES+2 cycles.
- PREADY, PSLVERR and PRDATA are registered (Moore) outputs with no combinational path from inputs.
- Inputs are sampled only in the setup cycle. Changes to PADDR or PWDATA during WAIT or DONE have no effect.

## Test plan
- Reset, then write 0xDEADBEEF to 0x010 with PSTRB=0xF and WAIT_STATES=1, then read 0x010 → PREADY high in T2 for both transfers; read returns 0xDEADBEEF; PSLVERR=0.
- Write 0xFFFFFFFF to 0x020, then write 0x11223344 with PSTRB=0x5, then read 0x020 → 0xFF22FF44.
- Read 0xC00 (word index 768 = DEPTH) and write 0xA5A5A5A5 to 0xC00 → PSLVERR=1 and PRDATA=0 in the DONE cycle; a read of 0x000 afterwards is unchanged.
- Rebuild with WAIT_STATES=0 and issue back-to-back writes to 0x004 and 0x008 with no idle cycle, then read both → each PREADY high in T1; both values are correct.
- Start a write to 0x030 (WAIT_STATES=3), drop PSEL in the second WAIT cycle, then read 0x030 → the old value is retained and no PREADY pulse occurs for the aborted transfer.
- Start a write to 0x040 and pulse PRESETn low mid-WAIT, asynchronously between edges → PREADY, PSLVERR and PRDATA are 0 immediately; a later read of 0x040 shows no write occurred.
